// File: rtl/cpu_step_controller.sv
// cpu_step_controller
// Gates a CPU one instruction at a time. Each cpu_en pulse commits exactly one
// instruction. The source of a pulse depends on the state:
//   - a debounced push-button press (single step, or resume from a breakpoint)
//   - a free-running RUN_DIV divider (run modes)
// In run-to-breakpoint mode the controller parks in BREAK when pc == bp_addr.
//
// Ports
//   clk          system clock, the only clock
//   rst          asynchronous, active-low reset
//   mode[1:0]    00 halt, 01 single-step, 10 free run, 11 run-to-breakpoint
//   step_n       raw push button, active-low, asynchronous to clk
//   pc           current CPU program counter
//   bp_addr      breakpoint address (used only in mode 11)
//   cnt_clr      synchronous clear of instr_count; wins over increment
//   cpu_en       registered one-cycle commit pulse
//   halted       high in HALT and BREAK
//   bp_hit       high in BREAK
//   state[1:0]   current FSM state
//   instr_count  number of cpu_en pulses issued, wraps at 2^32
//
// state | meaning
// ------+-------------------------------------------------------------
// HALT  | CPU held; no pulses
// STEP  | one pulse per debounced button press
// RUN   | one pulse every RUN_DIV cycles; mode 11 also watches bp_addr
// BRK   | parked on breakpoint; a press steps off it and resumes RUN

module cpu_step_controller #(
    parameter int unsigned RUN_DIV      = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic            step_n,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] bp_addr,
    input  logic            cnt_clr,
    output logic            cpu_en,
    output logic            halted,
    output logic            bp_hit,
    output logic [1:0]      state,
    output logic [31:0]     instr_count
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        BRK  = 2'b11
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(RUN_DIV - 1);
    localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYC - 1);

    state_t      state_q, state_d;
    logic        step_s1, step_s2;
    logic [23:0] deb_cnt;
    logic        deb_level, deb_prev;
    logic        press;
    logic [31:0] tick_cnt;
    logic        tick;
    logic        bp_match;
    logic        resume_mask, resume_d;
    logic        cpu_en_d;
    logic [31:0] count_q;

    // Two-stage synchroniser; idles high so reset does not look like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_s1 <= 1'b1;
            step_s2 <= 1'b1;
        end else begin
            step_s1 <= step_n;
            step_s2 <= step_s1;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYC consecutive cycles that
    // disagree with the current one; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b1;
            deb_prev  <= 1'b1;
        end else begin
            deb_prev <= deb_level;
            if (step_s2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= step_s2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 24'd1;
            end
        end
    end

    // Single-cycle event on the debounced falling edge; a held button gives one.
    assign press = deb_prev & ~deb_level;

    assign tick     = (state_q == RUN) && (tick_cnt == TICK_LAST);
    // Right after resuming from BREAK the CPU has not yet committed, so pc
    // still equals bp_addr for one cycle; ignore the match then.
    assign bp_match = (pc == bp_addr) && !resume_mask;

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        resume_d = 1'b0;
        case (state_q)
            HALT: begin
                case (mode)
                    2'b01:   state_d = STEP;
                    2'b10,
                    2'b11:   state_d = RUN;
                    default: state_d = HALT;
                endcase
            end
            STEP: begin
                case (mode)
                    2'b00:   state_d = HALT;
                    2'b10,
                    2'b11:   state_d = RUN;
                    default: cpu_en_d = press;
                endcase
            end
            RUN: begin
                case (mode)
                    2'b00:   state_d = HALT;
                    2'b01:   state_d = STEP;
                    2'b11: begin
                        // Breakpoint wins over a coincident tick.
                        if (bp_match) state_d = BRK;
                        else          cpu_en_d = tick;
                    end
                    default: cpu_en_d = tick;
                endcase
            end
            BRK: begin
                case (mode)
                    2'b00:   state_d = HALT;
                    2'b01:   state_d = STEP;
                    2'b10:   state_d = RUN;
                    default: begin
                        if (press) begin
                            cpu_en_d = 1'b1;
                            state_d  = RUN;
                            resume_d = 1'b1;
                        end
                    end
                endcase
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HALT;
            cpu_en      <= 1'b0;
            resume_mask <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_en      <= cpu_en_d;
            resume_mask <= resume_d;
        end
    end

    // Cleared on every state entry so the first run pulse lands RUN_DIV
    // cycles after entering RUN; only advances while in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if ((state_d != state_q) || (state_q != RUN) || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= '0;
        end else if (cpu_en) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
    assign state       = state_q;
    assign halted      = (state_q == HALT) || (state_q == BRK);
    assign bp_hit      = (state_q == BRK);

endmodule
